// File: rtl/apu_shared_unit.sv
// apu_shared_unit
//
// Shared integer APU sitting on one master port of the FPU interconnect
// crossbar. Requests are accepted under a req/gnt handshake. Every accepted
// request produces exactly one rvalid pulse carrying the requester ID.
// ADD/SUB/MUL/MAC and illegal opcodes go down a fixed-latency pipeline.
// DIV runs on an iterative restoring divider that produces one quotient bit
// per cycle. A reservation vector tracks which future cycles already own the
// single response port, so two results can never land on the same cycle.
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   apu_req_i       request valid
//   apu_gnt_o       request accepted this cycle (combinational)
//   apu_ID_i        requester ID (one-hot per core)
//   apu_operands_i  operands: [0]=a, [1]=b, [2]=c
//   apu_op_i        opcode: 0 ADD, 1 SUB, 2 MUL, 3 MAC, 4 DIV, others illegal
//   apu_flags_i     request flags (reserved, ignored)
//   apu_ready_i     response ready (tied high upstream, ignored)
//   apu_rvalid_o    one-cycle pulse per result
//   apu_rdata_o     result data, held while rvalid is low
//   apu_rflags_o    [0] div by zero, [1] carry/borrow, [2] illegal opcode
//   apu_rID_o       ID of the request that produced the result

module apu_shared_unit #(
  parameter int NB_APU_ARGS      = 3,
  parameter int DATA_WIDTH       = 32,
  parameter int APU_OPCODE_WIDTH = 5,
  parameter int FLAG_WIDTH       = 15,
  parameter int RFLAG_WIDTH      = 5,
  parameter int ID_WIDTH         = 2,
  parameter int PIPE_LAT         = 3
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    apu_req_i,
  output logic                                    apu_gnt_o,
  input  logic [ID_WIDTH-1:0]                     apu_ID_i,
  input  logic [NB_APU_ARGS-1:0][DATA_WIDTH-1:0]  apu_operands_i,
  input  logic [APU_OPCODE_WIDTH-1:0]             apu_op_i,
  input  logic [FLAG_WIDTH-1:0]                   apu_flags_i,
  input  logic                                    apu_ready_i,
  output logic                                    apu_rvalid_o,
  output logic [DATA_WIDTH-1:0]                   apu_rdata_o,
  output logic [RFLAG_WIDTH-1:0]                  apu_rflags_o,
  output logic [ID_WIDTH-1:0]                     apu_rID_o
);

  localparam int DIV_LAT = DATA_WIDTH + 2;
  localparam int CNT_W   = $clog2(DATA_WIDTH + 1);

  localparam logic [APU_OPCODE_WIDTH-1:0] OP_ADD = APU_OPCODE_WIDTH'(0);
  localparam logic [APU_OPCODE_WIDTH-1:0] OP_SUB = APU_OPCODE_WIDTH'(1);
  localparam logic [APU_OPCODE_WIDTH-1:0] OP_MUL = APU_OPCODE_WIDTH'(2);
  localparam logic [APU_OPCODE_WIDTH-1:0] OP_MAC = APU_OPCODE_WIDTH'(3);
  localparam logic [APU_OPCODE_WIDTH-1:0] OP_DIV = APU_OPCODE_WIDTH'(4);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  // Reserved and ready inputs carry no meaning for this unit.
  logic unused_inputs;
  assign unused_inputs = ^{apu_flags_i, apu_ready_i};

  logic [DATA_WIDTH-1:0] op_a, op_b, op_c;
  assign op_a = apu_operands_i[0];
  assign op_b = apu_operands_i[1];
  assign op_c = apu_operands_i[2];

  // resv[k] set means the response register is written at the k-th rising
  // edge from now (k=0 is the upcoming edge). Bit 0 therefore directly says
  // whether rvalid rises at the next edge.
  logic [DIV_LAT:0] resv, resv_next;

  div_state_t            div_state, div_state_next;
  logic [CNT_W-1:0]      div_cnt;
  logic [DATA_WIDTH-1:0] div_rem, div_quo, div_dvsr;
  logic [ID_WIDTH-1:0]   div_id;
  logic                  div_dz;
  logic [DATA_WIDTH:0]   div_shift, div_trial;

  logic is_div, can_accept, acc_pipe, acc_div;

  assign is_div     = (apu_op_i == OP_DIV);
  assign can_accept = is_div ? ((div_state == DIV_IDLE) && !resv[DIV_LAT])
                             : !resv[PIPE_LAT];
  assign apu_gnt_o  = rst_n & apu_req_i & can_accept;
  assign acc_pipe   = apu_gnt_o & ~is_div;
  assign acc_div    = apu_gnt_o & is_div;

  // Shift the reservations toward "now" and book the slot of a newly accepted
  // op. The booking lands one position below its latency because the vector
  // has already advanced by one edge when the new value becomes visible.
  always_comb begin
    resv_next = {1'b0, resv[DIV_LAT:1]};
    if (acc_pipe) resv_next[PIPE_LAT-1] = 1'b1;
    if (acc_div)  resv_next[DIV_LAT-1]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) resv <= '0;
    else        resv <= resv_next;
  end

  // The pipelined result is computed at accept time and then simply delayed.
  logic [DATA_WIDTH:0]    sum_ext;
  logic [DATA_WIDTH-1:0]  pipe_result;
  logic [RFLAG_WIDTH-1:0] pipe_flags;

  assign sum_ext = {1'b0, op_a} + {1'b0, op_b};

  always_comb begin
    pipe_result = '0;
    pipe_flags  = '0;
    case (apu_op_i)
      OP_ADD: begin
        pipe_result   = sum_ext[DATA_WIDTH-1:0];
        pipe_flags[1] = sum_ext[DATA_WIDTH];
      end
      OP_SUB: begin
        pipe_result   = op_a - op_b;
        pipe_flags[1] = (op_a < op_b);
      end
      OP_MUL: pipe_result = op_a * op_b;
      OP_MAC: pipe_result = op_a * op_b + op_c;
      OP_DIV: pipe_result = '0;
      default: pipe_flags[2] = 1'b1;
    endcase
  end

  // Delay line: stage i holds an op accepted i edges ago; the last stage
  // feeds the response register on the edge that its reservation names.
  logic                   pipe_valid [PIPE_LAT];
  logic [DATA_WIDTH-1:0]  pipe_data  [PIPE_LAT];
  logic [RFLAG_WIDTH-1:0] pipe_rflag [PIPE_LAT];
  logic [ID_WIDTH-1:0]    pipe_id    [PIPE_LAT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe_valid[i] <= 1'b0;
    end else begin
      pipe_valid[0] <= acc_pipe;
      pipe_data[0]  <= pipe_result;
      pipe_rflag[0] <= pipe_flags;
      pipe_id[0]    <= apu_ID_i;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
        pipe_rflag[i] <= pipe_rflag[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
    end
  end

  // Divider control: BUSY runs DATA_WIDTH quotient steps, then one cycle to
  // notice the counter hit zero and one DONE cycle that hands the result to
  // the response register. Load + DATA_WIDTH steps + 2 gives DIV_LAT.
  always_ff @(posedge clk) begin
    if (!rst_n) div_state <= DIV_IDLE;
    else        div_state <= div_state_next;
  end

  always_comb begin
    div_state_next = div_state;
    case (div_state)
      DIV_IDLE: if (acc_div) div_state_next = DIV_BUSY;
      DIV_BUSY: if (div_cnt == '0) div_state_next = DIV_DONE;
      DIV_DONE: div_state_next = DIV_IDLE;
      default:  div_state_next = DIV_IDLE;
    endcase
  end

  // Restoring step: shift the next dividend bit into the partial remainder
  // and keep the subtraction only when it does not borrow (bit DATA_WIDTH
  // of the trial difference is the borrow). A zero divisor never borrows,
  // so the quotient naturally fills with ones.
  assign div_shift = {div_rem, div_quo[DATA_WIDTH-1]};
  assign div_trial = div_shift - {1'b0, div_dvsr};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (acc_div) begin
      div_cnt  <= CNT_W'(DATA_WIDTH);
      div_rem  <= '0;
      div_quo  <= op_a;
      div_dvsr <= op_b;
      div_id   <= apu_ID_i;
      div_dz   <= (op_b == '0);
    end else if (div_state == DIV_BUSY && div_cnt != '0) begin
      div_cnt <= div_cnt - 1'b1;
      if (!div_trial[DATA_WIDTH]) begin
        div_rem <= div_trial[DATA_WIDTH-1:0];
        div_quo <= {div_quo[DATA_WIDTH-2:0], 1'b1};
      end else begin
        div_rem <= div_shift[DATA_WIDTH-1:0];
        div_quo <= {div_quo[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  // Response register. The reservation scheme guarantees the pipeline tail
  // and the DIV DONE state never coincide, so a priority mux is sufficient.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      apu_rvalid_o <= 1'b0;
      apu_rdata_o  <= '0;
      apu_rflags_o <= '0;
      apu_rID_o    <= '0;
    end else begin
      apu_rvalid_o <= resv[0];
      if (pipe_valid[PIPE_LAT-1]) begin
        apu_rdata_o  <= pipe_data[PIPE_LAT-1];
        apu_rflags_o <= pipe_rflag[PIPE_LAT-1];
        apu_rID_o    <= pipe_id[PIPE_LAT-1];
      end else if (div_state == DIV_DONE) begin
        apu_rdata_o  <= div_dz ? '1 : div_quo;
        apu_rflags_o <= RFLAG_WIDTH'(div_dz);
        apu_rID_o    <= div_id;
      end
    end
  end

endmodule

// File: tb/tb_apu_shared_unit.sv
// tb_apu_shared_unit
//
// Scoreboard bench for apu_shared_unit. The driver issues one request per
// cycle, predicts the grant from the set of result slots it already knows
// are booked, and pushes the expected result with its completion cycle.
// The monitor independently pops whatever is due each cycle and compares.

module tb_apu_shared_unit;

  localparam int DW       = 32;
  localparam int OPW      = 5;
  localparam int IDW      = 2;
  localparam int RFW      = 5;
  localparam int PIPE_LAT = 3;
  localparam int DIV_LAT  = DW + 2;

  localparam logic [OPW-1:0] OP_ADD = 5'd0;
  localparam logic [OPW-1:0] OP_SUB = 5'd1;
  localparam logic [OPW-1:0] OP_MUL = 5'd2;
  localparam logic [OPW-1:0] OP_MAC = 5'd3;
  localparam logic [OPW-1:0] OP_DIV = 5'd4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                apu_req_i = 1'b0;
  logic                apu_gnt_o;
  logic [IDW-1:0]      apu_ID_i = '0;
  logic [2:0][DW-1:0]  apu_operands_i = '0;
  logic [OPW-1:0]      apu_op_i = '0;
  logic [14:0]         apu_flags_i = '0;
  logic                apu_ready_i = 1'b0;
  logic                apu_rvalid_o;
  logic [DW-1:0]       apu_rdata_o;
  logic [RFW-1:0]      apu_rflags_o;
  logic [IDW-1:0]      apu_rID_o;

  apu_shared_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .apu_req_i      (apu_req_i),
    .apu_gnt_o      (apu_gnt_o),
    .apu_ID_i       (apu_ID_i),
    .apu_operands_i (apu_operands_i),
    .apu_op_i       (apu_op_i),
    .apu_flags_i    (apu_flags_i),
    .apu_ready_i    (apu_ready_i),
    .apu_rvalid_o   (apu_rvalid_o),
    .apu_rdata_o    (apu_rdata_o),
    .apu_rflags_o   (apu_rflags_o),
    .apu_rID_o      (apu_rID_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             due;
    bit             is_div;
    logic [DW-1:0]  data;
    logic [RFW-1:0] flags;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0]  last_data  = '0;
  logic [RFW-1:0] last_flags = '0;
  logic [IDW-1:0] last_id    = '0;

  // cyc equals the number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, want 0x%0h",
               name, cyc, actual, expected);
    end
  endtask

  // Reference arithmetic done in 64 bits, then truncated.
  function automatic void model_result(input logic [OPW-1:0] op,
                                       input logic [DW-1:0] a, b, c,
                                       output logic [DW-1:0] data,
                                       output logic [RFW-1:0] flags);
    logic [63:0] wide;
    data  = '0;
    flags = '0;
    case (op)
      OP_ADD: begin
        wide = {32'b0, a} + {32'b0, b};
        data = wide[31:0];
        flags[1] = wide[32];
      end
      OP_SUB: begin
        data = a - b;
        flags[1] = (a < b);
      end
      OP_MUL: begin
        wide = {32'b0, a} * {32'b0, b};
        data = wide[31:0];
      end
      OP_MAC: begin
        wide = {32'b0, a} * {32'b0, b} + {32'b0, c};
        data = wide[31:0];
      end
      OP_DIV: begin
        if (b == '0) begin
          data = '1;
          flags[0] = 1'b1;
        end else begin
          data = a / b;
        end
      end
      default: flags[2] = 1'b1;
    endcase
  endfunction

  // A request is granted when its completion cycle is not already booked;
  // a DIV additionally needs no earlier DIV still owning the divider.
  function automatic bit predict_gnt(input bit req, input bit rst_ok,
                                     input logic [OPW-1:0] op,
                                     input int acc_edge);
    if (!req || !rst_ok) return 1'b0;
    if (op == OP_DIV) begin
      foreach (sb[i]) if (sb[i].is_div && sb[i].due >= acc_edge) return 1'b0;
      foreach (sb[i]) if (sb[i].due == acc_edge + DIV_LAT) return 1'b0;
      return 1'b1;
    end
    foreach (sb[i]) if (sb[i].due == acc_edge + PIPE_LAT) return 1'b0;
    return 1'b1;
  endfunction

  task automatic applyStimulus(input bit req, input logic [OPW-1:0] op,
                               input logic [DW-1:0] a, b, c,
                               input logic [IDW-1:0] id);
    bit   exp_gnt;
    exp_t e;
    @(negedge clk);
    apu_req_i         = req;
    apu_op_i          = op;
    apu_operands_i[0] = a;
    apu_operands_i[1] = b;
    apu_operands_i[2] = c;
    apu_ID_i          = id;
    apu_flags_i       = 15'($urandom);
    #1;
    exp_gnt = predict_gnt(req, rst_n, op, cyc + 1);
    checkOutput("gnt", apu_gnt_o, exp_gnt);
    if (exp_gnt) begin
      e.is_div = (op == OP_DIV);
      e.due    = cyc + 1 + (e.is_div ? DIV_LAT : PIPE_LAT);
      e.id     = id;
      model_result(op, a, b, c, e.data, e.flags);
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, OP_ADD, '0, '0, '0, '0);
  endtask

  // Reset wipes everything in flight, so the expectations go too.
  task automatic assertReset();
    @(negedge clk);
    #2;
    rst_n      = 1'b0;
    apu_req_i  = 1'b0;
    sb.delete();
    last_data  = '0;
    last_flags = '0;
    last_id    = '0;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    #2;
    rst_n     = 1'b1;
    apu_req_i = 1'b0;
  endtask

  // Monitor: whatever is due this cycle must appear now with matching
  // contents; otherwise rvalid stays low and the outputs hold.
  always @(negedge clk) begin : monitor
    int idx;
    idx = -1;
    foreach (sb[i]) if (sb[i].due == cyc) idx = i;
    checkOutput("rvalid", apu_rvalid_o, (idx >= 0));
    if (idx >= 0) begin
      if (apu_rvalid_o === 1'b1) begin
        checkOutput("rdata", apu_rdata_o, sb[idx].data);
        checkOutput("rflags", apu_rflags_o, sb[idx].flags);
        checkOutput("rID", apu_rID_o, sb[idx].id);
      end
      last_data  = sb[idx].data;
      last_flags = sb[idx].flags;
      last_id    = sb[idx].id;
      sb.delete(idx);
    end else begin
      checkOutput("hold_rdata", apu_rdata_o, last_data);
      checkOutput("hold_rflags", apu_rflags_o, last_flags);
      checkOutput("hold_rID", apu_rID_o, last_id);
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    logic [OPW-1:0] rop;
    logic [DW-1:0]  ra, rb;
    int             sel;

    // requests during reset must never be granted
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd2, '0, 2'b01);
    applyStimulus(1'b1, OP_DIV, 32'd9, 32'd3, '0, 2'b10);
    releaseReset();

    $display("[TB] add/sub");
    applyStimulus(1'b1, OP_ADD, 32'd5, 32'd7, '0, 2'b01);
    applyStimulus(1'b1, OP_SUB, 32'd3, 32'd5, '0, 2'b10);
    applyStimulus(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd2, '0, 2'b01);
    idle(5);

    $display("[TB] mac stream");
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, OP_MAC, DW'(i), 32'd2, 32'd1, IDW'(i));
    idle(5);

    $display("[TB] divide and slot conflict");
    applyStimulus(1'b1, OP_DIV, 32'd100, 32'd7, '0, 2'b01);
    for (int i = 0; i < 30; i++)
      applyStimulus(1'b1, OP_DIV, 32'd50, 32'd5, '0, 2'b10);
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, '0, 2'b10);
    applyStimulus(1'b1, OP_ADD, 32'd1, 32'd1, '0, 2'b10);
    idle(5);
    applyStimulus(1'b1, OP_DIV, 32'd12345, 32'd0, '0, 2'b10);
    idle(DIV_LAT + 4);

    $display("[TB] illegal opcode");
    applyStimulus(1'b1, 5'd9, 32'd5, 32'd6, 32'd7, 2'b11);
    idle(5);

    $display("[TB] reset with ops in flight");
    applyStimulus(1'b1, OP_DIV, 32'd1000, 32'd3, '0, 2'b01);
    applyStimulus(1'b1, OP_ADD, 32'd10, 32'd20, '0, 2'b10);
    applyStimulus(1'b1, OP_MUL, 32'd6, 32'd7, '0, 2'b11);
    assertReset();
    releaseReset();
    idle(DIV_LAT + 6);
    applyStimulus(1'b1, OP_ADD, 32'd8, 32'd9, '0, 2'b01);
    idle(5);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      rop = OPW'($urandom_range(0, 3));
      else if (sel < 9) rop = OP_DIV;
      else              rop = OPW'($urandom_range(5, 31));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = DW'($urandom_range(1, 1000));
        default: rb = $urandom;
      endcase
      applyStimulus($urandom_range(0, 4) != 0, rop, ra, rb, $urandom,
                    IDW'($urandom));
    end
    idle(DIV_LAT + 10);

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
